apb_slave_regbank_array: RTL
============================

// Module: apb_slave_regbank_array
// PURPOSE
//  Parametrised APB completer: NUM_SLAVES independent word-addressed register banks behind the bridge's Pselx lines.
//  Replaces the fixed-return-value APB interface with real storage, wait-state insertion, Pready and Pslverr.
//  Sits downstream of the AHB-to-APB bridge FSM as the peripheral model for the APB side of the design.
// PARAMETERS
//  ADDR_WIDTH   32  Paddr width
//  DATA_WIDTH   32  Pwdata/Prdata width
//  NUM_SLAVES   3   number of Pselx lines / banks
//  DEPTH        16  words per bank, power of 2, >=2; IDX_W = $clog2(DEPTH)
//  WAIT_STATES  0   Pready-low cycles inserted in ACCESS, 0..15
// PORTS
//  Hclk     in   1            clock, all state on rising edge
//  Hresetn  in   1            asynchronous active-low reset
//  Pselx    in   NUM_SLAVES   one-hot bank select
//  Penable  in   1            APB access phase
//  Pwrite   in   1            1 = write, 0 = read
//  Paddr    in   ADDR_WIDTH   byte address; word index = Paddr[IDX_W+1:2]
//  Pwdata   in   DATA_WIDTH   write data
//  Prdata   out  DATA_WIDTH   read data, valid while Pready=1 on a read
//  Pready   out  1            transfer completes on edge where Penable & Pready
//  Pslverr  out  1            error response, valid only while Pready=1
// BEHAVIOUR
//  - Reset (async, Hresetn=0): state IDLE, wait counter 0, Prdata 0, Pready 0, Pslverr 0, all bank words 0.
//  - FSM IDLE: |Pselx & !Penable -> ACCESS; latch address, write flag, bank index, error flag; load cnt=WAIT_STATES;
//    on a read, load Prdata from addressed word (0 if error).
//  - ACCESS: Pready = (cnt==0), combinational from registered state. Penable=1 & cnt!=0 -> cnt--.
//    Penable=1 & cnt==0 -> transfer completes: write commits Pwdata to latched word (only if no error); -> IDLE.
//  - Back-to-back: completion edge returns to IDLE; next SETUP is the following cycle; min 2 cycles/transfer at WAIT_STATES=0.
//  - Pselx deasserted or Penable low while in ACCESS after the first cycle: abort -> IDLE, no write, Prdata unchanged.
//  - Pready, Pslverr are 0 in IDLE. Prdata holds last loaded value between transfers.
//  - Error conditions: Paddr[1:0]!=0; Paddr[ADDR_WIDTH-1:IDX_W+2]!=0; more than one Pselx bit set.
//  - Reset asserted mid-ACCESS: transfer dropped, no write, all outputs to reset values immediately.
//  - Banks are independent: a write to bank k never alters bank j!=k.
// CONFIGURATION
//  APB_SLVERR_EN defined: error conditions drive Pslverr=1 with Pready; write suppressed; read returns 0.
//  APB_SLVERR_EN undefined: Pslverr tied 0; address bits above IDX_W+1 and Paddr[1:0] ignored (index wraps modulo DEPTH);
//    multiple Pselx bits -> lowest set index wins; every transfer commits normally.
// STRUCTURE
//  Package apb_regbank_pkg: state enum {IDLE, ACCESS}; APB_WORD_BYTES=4; function clog2 helper; error-code localparams.
//  Sub-module apb_regbank_mem: one DEPTH x DATA_WIDTH bank, async-clear, single write port (we, idx, wdata), comb read port;
//    instantiated NUM_SLAVES times via generate; top holds FSM, counter, decode, Pslverr/Prdata registers.
// TESTING
//  1. Reset then WAIT_STATES=0: write 0xDEADBEEF to bank1 Paddr=0x08, read back -> Prdata=0xDEADBEEF, Pready=1 in 2nd cycle, Pslverr=0.
//  2. WAIT_STATES=3: read bank0 Paddr=0x04 -> Pready low exactly 3 ACCESS cycles, high on 4th; transfer = 5 cycles total.
//  3. Bank isolation: write 0x11 to bank0 idx2, 0x22 to bank2 idx2 -> reads return 0x11 and 0x22; bank1 idx2 reads 0.
//  4. With APB_SLVERR_EN: write Paddr=0x40 (DEPTH=16) -> Pslverr=1 with Pready; readback of idx0 still 0. Without: same write lands at idx0.
//  5. Pselx=3'b011 write 0x55 idx0: with macro Pslverr=1, nothing written; without, bank0 idx0=0x55, bank1 untouched.
//  6. Hresetn pulsed low during ACCESS with WAIT_STATES=2 write pending -> no write, Pready=0, Prdata=0, all words read 0.
//  7. Abort: drop Penable after 1 ACCESS cycle at WAIT_STATES=2 -> FSM IDLE, target word unchanged.

Source files
------------

// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register-bank completer.
package apb_regbank_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int APB_WORD_BYTES = 4;
  localparam int CNT_W          = 4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_MULTI = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// One DEPTH x DATA_WIDTH register bank: async-clear, one write port, combinational read port.
module apb_regbank_mem
  import apb_regbank_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = clog2(DEPTH)
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_regbank_array.sv
// APB completer with NUM_SLAVES independent register banks, wait states, Pready and Pslverr.
// APB_SLVERR_EN enables error responses; undefined, every transfer commits with wrapped indexing.
module apb_slave_regbank_array
  import apb_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W  = clog2(DEPTH);
  localparam int OFS_W  = clog2(APB_WORD_BYTES);
  localparam int BSEL_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    wr_q, err_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BSEL_W-1:0]       bank_q;
  logic                    start, done, cnt_zero, err_now;
  logic [IDX_W-1:0]        addr_idx;
  logic [BSEL_W-1:0]       sel_bank;
  logic [1:0]              err_code;
  logic [NUM_SLAVES-1:0]   bank_we;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] bank_rdata;

  assign addr_idx = Paddr[IDX_W+OFS_W-1:OFS_W];
  assign cnt_zero = (cnt == '0);

  // Lowest set select bit wins; only matters when errors are not reported.
  always_comb begin
    sel_bank = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--)
      if (Pselx[k]) sel_bank = BSEL_W'(k);
  end

  always_comb begin
    err_code = ERR_NONE;
    if (Paddr[OFS_W-1:0] != '0)                       err_code = ERR_ALIGN;
    else if (Paddr[ADDR_WIDTH-1:IDX_W+OFS_W] != '0)   err_code = ERR_RANGE;
    else if (!$onehot(Pselx))                         err_code = ERR_MULTI;
  end

`ifdef APB_SLVERR_EN
  assign err_now = (err_code != ERR_NONE);
`else
  logic unused_err;
  assign unused_err = ^err_code;
  assign err_now    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:
        if (|Pselx && !Penable) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      ACCESS:
        if (!(|Pselx) || !Penable) begin
          state_nxt = IDLE;
        end else if (cnt_zero) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      bank_q <= '0;
      Prdata <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt    <= CNT_W'(WAIT_STATES);
        wr_q   <= Pwrite;
        err_q  <= err_now;
        idx_q  <= addr_idx;
        bank_q <= sel_bank;
        // Read data is captured at SETUP so it is stable for the whole ACCESS phase.
        if (!Pwrite) Prdata <= err_now ? '0 : bank_rdata[sel_bank];
      end else if (state == ACCESS && Penable && |Pselx && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign Pready = (state == ACCESS) && cnt_zero;

`ifdef APB_SLVERR_EN
  assign Pslverr = Pready && err_q;
`else
  assign Pslverr = 1'b0;
`endif

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_bank
    assign bank_we[k] = done && wr_q && !err_q && (bank_q == BSEL_W'(k));

    apb_regbank_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
    ) u_mem (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .we      (bank_we[k]),
      .widx    (idx_q),
      .wdata   (Pwdata),
      .ridx    (addr_idx),
      .rdata   (bank_rdata[k])
    );
  end

endmodule
